// File: rtl/puf_race_launcher.sv
// Arbiter-PUF stimulus sequencer. It launches majority-voted race trials per challenge and returns the response.
// Optional soft-information output (unstable-bit count) is enabled by defining PUF_SOFT_INFO_EN.
module puf_race_launcher #(
  parameter int DATA_WIDTH     = 32,
  parameter int CHAL_WIDTH     = 64,
  parameter int SETTLE_CYCLES  = 16,
  parameter int CAPTURE_CYCLES = 8,
  parameter int VOTE_COUNT     = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  chal_valid,
  output logic                  chal_ready,
  input  logic [CHAL_WIDTH-1:0] chal_data,
  output logic [CHAL_WIDTH-1:0] pdl_chal,
  output logic                  launch,
  input  logic                  arb_q,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_data,
`ifdef PUF_SOFT_INFO_EN
  output logic [$clog2(DATA_WIDTH+1)-1:0] resp_unstable,
`endif
  output logic                  busy
);

  // state  | meaning
  // IDLE   | waiting for a challenge, chal_ready high
  // SETTLE | launch low, delay paths reset, PDL select settling
  // FIRE   | launch high, race in flight, sample on the last cycle
  // DONE   | response held until the consumer takes it
  typedef enum logic [1:0] {IDLE, SETTLE, FIRE, DONE} state_t;

  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_WIDTH - 1);
  localparam logic [7:0]    SET_FIRST = 8'(SETTLE_CYCLES);
  localparam logic [7:0]    SET_LD    = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0]    CAP_LD    = 8'(CAPTURE_CYCLES - 1);
  localparam logic [3:0]    VOTES     = 4'(VOTE_COUNT);
  localparam logic [3:0]    HALF      = 4'(VOTE_COUNT / 2);

  state_t                  state_q;
  logic [1:0]              sync_q;
  logic [7:0]              cnt_q;
  logic [3:0]              trial_q, ones_q;
  logic [BW-1:0]           bit_idx_q;
  logic [CHAL_WIDTH-1:0]   chal_q, pdl_q;
  logic [DATA_WIDTH-1:0]   resp_q;
  logic                    launch_q, resp_valid_q, chal_ready_q, busy_q;
  logic [3:0]              ones_d, trial_d;
  logic                    vote_bit, unanimous;
`ifdef PUF_SOFT_INFO_EN
  logic [$clog2(DATA_WIDTH+1)-1:0] unstable_q;
  assign resp_unstable = unstable_q;
`endif

  function automatic logic [CHAL_WIDTH-1:0] rotl(input logic [CHAL_WIDTH-1:0] c,
                                                 input int unsigned amt);
    logic [2*CHAL_WIDTH-1:0] dbl;
    dbl = {c, c} << amt;
    return dbl[2*CHAL_WIDTH-1:CHAL_WIDTH];
  endfunction

  always_comb begin
    ones_d    = ones_q + {3'b000, sync_q[1]};
    trial_d   = trial_q + 4'd1;
    vote_bit  = (ones_d > HALF);
    unanimous = (ones_d == 4'd0) || (ones_d == VOTES);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], arb_q};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      trial_q      <= '0;
      ones_q       <= '0;
      bit_idx_q    <= '0;
      chal_q       <= '0;
      pdl_q        <= '0;
      resp_q       <= '0;
      launch_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      chal_ready_q <= 1'b1;
      busy_q       <= 1'b0;
`ifdef PUF_SOFT_INFO_EN
      unstable_q   <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: if (chal_valid && chal_ready_q) begin
          chal_q       <= chal_data;
          pdl_q        <= chal_data;
          bit_idx_q    <= '0;
          trial_q      <= '0;
          ones_q       <= '0;
          resp_q       <= '0;
          // first settle carries one extra cycle for the freshly latched select lines
          cnt_q        <= SET_FIRST;
          chal_ready_q <= 1'b0;
          busy_q       <= 1'b1;
          state_q      <= SETTLE;
`ifdef PUF_SOFT_INFO_EN
          unstable_q   <= '0;
`endif
        end
        SETTLE: if (cnt_q == 8'd0) begin
          cnt_q    <= CAP_LD;
          launch_q <= 1'b1;
          state_q  <= FIRE;
        end else begin
          cnt_q <= cnt_q - 8'd1;
        end
        FIRE: if (cnt_q != 8'd0) begin
          cnt_q <= cnt_q - 8'd1;
        end else begin
          launch_q <= 1'b0;
          if (trial_d < VOTES) begin
            ones_q  <= ones_d;
            trial_q <= trial_d;
            cnt_q   <= SET_LD;
            state_q <= SETTLE;
          end else begin
            ones_q            <= '0;
            trial_q           <= '0;
            resp_q[bit_idx_q] <= vote_bit;
`ifdef PUF_SOFT_INFO_EN
            if (!unanimous) unstable_q <= unstable_q + 1'b1;
`endif
            if (bit_idx_q < LAST_BIT) begin
              bit_idx_q <= bit_idx_q + 1'b1;
              pdl_q     <= rotl(chal_q, (int'(bit_idx_q) + 1) % CHAL_WIDTH);
              cnt_q     <= SET_LD;
              state_q   <= SETTLE;
            end else begin
              resp_valid_q <= 1'b1;
              state_q      <= DONE;
            end
          end
        end
        DONE: if (resp_ready) begin
          resp_valid_q <= 1'b0;
          chal_ready_q <= 1'b1;
          busy_q       <= 1'b0;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign chal_ready = chal_ready_q;
  assign pdl_chal   = pdl_q;
  assign launch     = launch_q;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_q;
  assign busy       = busy_q;

`ifndef PUF_SOFT_INFO_EN
  logic unused_ok;
  assign unused_ok = unanimous;
`endif

endmodule

// File: tb/tb_puf_race_launcher.sv
// Self-checking bench for puf_race_launcher: randomized arbiter votes against a majority/rotation model.
// Soft-information checks are compiled in when PUF_SOFT_INFO_EN is defined.
module tb_puf_race_launcher;
  localparam int DW = 32, CW = 64, S = 16, C = 8, V = 5;
  localparam int NTRIAL = DW * V;
  localparam int LAT = DW * V * (S + C) + 1;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          chal_valid = 1'b0, resp_ready = 1'b0, arb_q = 1'b0;
  logic [CW-1:0] chal_data = '0;
  logic          chal_ready, launch, resp_valid, busy;
  logic [CW-1:0] pdl_chal;
  logic [DW-1:0] resp_data;
`ifdef PUF_SOFT_INFO_EN
  logic [$clog2(DW+1)-1:0] resp_unstable;
`endif

  int passed = 0, total = 0;
  bit            plan[NTRIAL];
  logic [CW-1:0] pdl_log[NTRIAL];
  int plan_base = 0, launch_cnt = 0;
  logic launch_prev = 1'b0;

  always #5 clk = ~clk;

  puf_race_launcher #(.DATA_WIDTH(DW), .CHAL_WIDTH(CW), .SETTLE_CYCLES(S),
                      .CAPTURE_CYCLES(C), .VOTE_COUNT(V)) dut (
    .clk(clk), .rst_n(rst_n), .chal_valid(chal_valid), .chal_ready(chal_ready),
    .chal_data(chal_data), .pdl_chal(pdl_chal), .launch(launch), .arb_q(arb_q),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
`ifdef PUF_SOFT_INFO_EN
    .resp_unstable(resp_unstable),
`endif
    .busy(busy));

  // Arbiter model: each launch edge takes the next planned race outcome and logs the select lines.
  initial begin
    int idx;
    forever begin
      @(negedge clk);
      if (launch && !launch_prev) begin
        idx = launch_cnt - plan_base;
        if (idx >= 0 && idx < NTRIAL) begin
          arb_q = plan[idx];
          pdl_log[idx] = pdl_chal;
        end
        launch_cnt++;
      end
      launch_prev = launch;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time exhausted");
    $fatal(1);
  end

  function automatic logic [CW-1:0] rot_model(input logic [CW-1:0] c, input int k);
    int m;
    m = k % CW;
    if (m == 0) return c;
    return (c << m) | (c >> (CW - m));
  endfunction

  function automatic logic [DW-1:0] exp_resp();
    logic [DW-1:0] r;
    int ones;
    r = '0;
    for (int b = 0; b < DW; b++) begin
      ones = 0;
      for (int t = 0; t < V; t++) ones += int'(plan[b*V+t]);
      r[b] = (2 * ones > V);
    end
    return r;
  endfunction

  function automatic int exp_unstable();
    int n, ones;
    n = 0;
    for (int b = 0; b < DW; b++) begin
      ones = 0;
      for (int t = 0; t < V; t++) ones += int'(plan[b*V+t]);
      if (ones != 0 && ones != V) n++;
    end
    return n;
  endfunction

  task automatic fill_random();
    for (int i = 0; i < NTRIAL; i++) plan[i] = 1'($urandom_range(0, 1));
  endtask

  task automatic set_bit_ones(input int b, input int k);
    int off;
    off = $urandom_range(0, V - 1);
    for (int t = 0; t < V; t++) plan[b*V + ((t + off) % V)] = (t < k);
  endtask

  task automatic start_challenge(input logic [CW-1:0] chal);
    plan_base = launch_cnt;
    @(negedge clk);
    chal_data  = chal;
    chal_valid = 1'b1;
    @(posedge clk);
    #1 chal_valid = 1'b0;
  endtask

  task automatic run_challenge(input logic [CW-1:0] chal, output int lat,
                               output logic [DW-1:0] got);
    start_challenge(chal);
    lat = 0;
    while (lat < LAT + 100) begin
      @(posedge clk);
      #1 lat++;
      if (resp_valid) break;
    end
    got = resp_data;
  endtask

  task automatic finish_resp();
    @(negedge clk);
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (chal_ready !== 1'b1) $display("FAIL reset_chal_ready: got %b exp 1", chal_ready); else passed++;
    total++; if (pdl_chal !== '0) $display("FAIL reset_pdl: got %h exp 0", pdl_chal); else passed++;
    total++; if (launch !== 1'b0) $display("FAIL reset_launch: got %b exp 0", launch); else passed++;
    total++; if (resp_valid !== 1'b0) $display("FAIL reset_resp_valid: got %b exp 0", resp_valid); else passed++;
    total++; if (resp_data !== '0) $display("FAIL reset_resp_data: got %h exp 0", resp_data); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b exp 0", busy); else passed++;
  endtask

  task automatic test_all_ones();
    int lat;
    logic [DW-1:0] got;
    for (int i = 0; i < NTRIAL; i++) plan[i] = 1'b1;
    run_challenge(64'h0123_4567_89AB_CDEF, lat, got);
    total++; if (lat !== LAT) $display("FAIL ones_latency: got %0d exp %0d", lat, LAT); else passed++;
    total++; if (got !== exp_resp()) $display("FAIL ones_resp: got %h exp %h", got, exp_resp()); else passed++;
    total++; if (got !== 32'hFFFF_FFFF) $display("FAIL ones_resp_const: got %h exp ffffffff", got); else passed++;
    total++; if (launch_cnt - plan_base !== NTRIAL) $display("FAIL ones_launches: got %0d exp %0d", launch_cnt - plan_base, NTRIAL); else passed++;
    total++; if (busy !== 1'b1 || chal_ready !== 1'b0) $display("FAIL done_flags: got busy %b ready %b exp 1 0", busy, chal_ready); else passed++;
    finish_resp();
    total++; if (resp_valid !== 1'b0 || chal_ready !== 1'b1 || busy !== 1'b0) $display("FAIL ones_handshake: got v %b r %b b %b exp 0 1 0", resp_valid, chal_ready, busy); else passed++;
  endtask

  task automatic test_rotation();
    int lat;
    logic [CW-1:0] c;
    logic [DW-1:0] got;
    c = 64'h1;
    for (int i = 0; i < NTRIAL; i++) plan[i] = 1'b0;
    run_challenge(c, lat, got);
    total++; if (lat !== LAT) $display("FAIL rot_latency: got %0d exp %0d", lat, LAT); else passed++;
    total++; if (got !== '0) $display("FAIL rot_resp: got %h exp 0", got); else passed++;
    total++; if (pdl_log[0] !== 64'h1) $display("FAIL rot_bit0: got %h exp 1", pdl_log[0]); else passed++;
    total++; if (pdl_log[V] !== 64'h2) $display("FAIL rot_bit1: got %h exp 2", pdl_log[V]); else passed++;
    total++; if (pdl_log[31*V] !== 64'h8000_0000) $display("FAIL rot_bit31: got %h exp 80000000", pdl_log[31*V]); else passed++;
    for (int i = 0; i < NTRIAL; i++) begin
      total++;
      if (pdl_log[i] !== rot_model(c, i / V)) $display("FAIL rot_trial%0d: got %h exp %h", i, pdl_log[i], rot_model(c, i / V));
      else passed++;
    end
    finish_resp();
  endtask

  task automatic test_majority();
    int lat;
    logic [DW-1:0] got;
    fill_random();
    set_bit_ones(0, 2);
    set_bit_ones(1, 3);
    run_challenge({$urandom, $urandom}, lat, got);
    total++; if (lat !== LAT) $display("FAIL maj_latency: got %0d exp %0d", lat, LAT); else passed++;
    total++; if (got !== exp_resp()) $display("FAIL maj_resp: got %h exp %h", got, exp_resp()); else passed++;
    total++; if (got[0] !== 1'b0) $display("FAIL maj_2of5: got %b exp 0", got[0]); else passed++;
    total++; if (got[1] !== 1'b1) $display("FAIL maj_3of5: got %b exp 1", got[1]); else passed++;
`ifdef PUF_SOFT_INFO_EN
    total++; if (int'(resp_unstable) !== exp_unstable()) $display("FAIL maj_unstable: got %0d exp %0d", resp_unstable, exp_unstable()); else passed++;
`endif
    finish_resp();
  endtask

`ifdef PUF_SOFT_INFO_EN
  task automatic test_soft_info();
    int lat;
    logic [DW-1:0] got;
    for (int b = 0; b < DW; b++) set_bit_ones(b, (b % 2 == 0) ? 3 : ($urandom_range(0, 1) * V));
    run_challenge({$urandom, $urandom}, lat, got);
    total++; if (got !== exp_resp()) $display("FAIL soft_resp: got %h exp %h", got, exp_resp()); else passed++;
    total++; if (int'(resp_unstable) !== 16) $display("FAIL soft_unstable: got %0d exp 16", resp_unstable); else passed++;
    finish_resp();
  endtask
`endif

  task automatic test_backpressure();
    int lat;
    logic [DW-1:0] got;
    logic [CW-1:0] pdl_hold;
    fill_random();
    run_challenge({$urandom, $urandom}, lat, got);
    total++; if (got !== exp_resp()) $display("FAIL bp_resp: got %h exp %h", got, exp_resp()); else passed++;
    pdl_hold = pdl_chal;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++;
      if (resp_valid !== 1'b1 || resp_data !== got || chal_ready !== 1'b0)
        $display("FAIL bp_hold%0d: got v %b d %h r %b exp 1 %h 0", i, resp_valid, resp_data, chal_ready, got);
      else passed++;
      chal_valid = (i == 4);
      chal_data  = ~pdl_hold;
    end
    @(negedge clk);
    chal_valid = 1'b0;
    total++; if (busy !== 1'b1 || pdl_chal !== pdl_hold) $display("FAIL bp_ignored: got busy %b pdl %h exp 1 %h", busy, pdl_chal, pdl_hold); else passed++;
    resp_ready = 1'b1;
    chal_valid = 1'b1;
    @(posedge clk);
    #1;
    total++; if (resp_valid !== 1'b0 || chal_ready !== 1'b1 || busy !== 1'b0) $display("FAIL bp_release: got v %b r %b b %b exp 0 1 0", resp_valid, chal_ready, busy); else passed++;
    @(negedge clk);
    chal_valid = 1'b0;
    resp_ready = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b0) $display("FAIL bp_no_same_cycle_accept: got busy %b exp 0", busy); else passed++;
  endtask

  task automatic test_reset_mid();
    int lat, cyc;
    logic [DW-1:0] got;
    fill_random();
    start_challenge({$urandom, $urandom});
    cyc = 0;
    while (launch_cnt - plan_base < 7 * V + 1 && cyc < LAT) begin
      @(negedge clk);
      cyc++;
    end
    total++; if (launch_cnt - plan_base !== 7 * V + 1) $display("FAIL rst_reach_bit7: got %0d launches exp %0d", launch_cnt - plan_base, 7 * V + 1); else passed++;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++; if (launch !== 1'b0) $display("FAIL rst_launch_async: got %b exp 0", launch); else passed++;
    total++; if (resp_valid !== 1'b0 || pdl_chal !== '0 || resp_data !== '0) $display("FAIL rst_outputs: got v %b pdl %h d %h exp 0 0 0", resp_valid, pdl_chal, resp_data); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (chal_ready !== 1'b1 || busy !== 1'b0) $display("FAIL rst_release: got r %b b %b exp 1 0", chal_ready, busy); else passed++;
    fill_random();
    run_challenge({$urandom, $urandom}, lat, got);
    total++; if (lat !== LAT) $display("FAIL rst_next_latency: got %0d exp %0d", lat, LAT); else passed++;
    total++; if (got !== exp_resp()) $display("FAIL rst_next_resp: got %h exp %h", got, exp_resp()); else passed++;
    finish_resp();
  endtask

  initial begin
    test_reset();
    test_all_ones();
    test_rotation();
    test_majority();
`ifdef PUF_SOFT_INFO_EN
    test_soft_info();
`endif
    test_backpressure();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
